// File: rtl/uart_tx_sched.sv
// Telemetry scheduler in front of the uart u_req/u_ack interface: decimates NCH sources
// on a millisecond tick, sequence-stamps samples and grants them round-robin one at a time.
module uart_tx_sched #(
    parameter int NCH      = 7,
    parameter int WIDTH    = 63,
    parameter int PER_W    = 16,
    parameter int TICK_DIV = 50000,
    parameter int ACK_TO   = 64
) (
    input  logic                     rstn,
    input  logic                     clk_50m,
    input  logic [NCH-1:0]           cfg_en,
    input  logic [NCH*PER_W-1:0]     cfg_period,
    input  logic [NCH-1:0]           src_valid,
    input  logic [NCH*(WIDTH+1)-1:0] src_data,
    output logic [NCH-1:0]           u_req,
    input  logic [NCH-1:0]           u_ack,
    output logic [NCH*(WIDTH+1)-1:0] m_msg,
    output logic [15:0]              drop_cnt,
    output logic [7:0]               tmo_cnt,
    output logic                     busy
);
    localparam int MW = WIDTH + 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = CW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] TO_MAX   = OW'(ACK_TO - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);
    localparam logic [SW-1:0] NCH_S    = SW'(NCH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLOW} state_t;
    state_t state, state_nxt;

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [PER_W-1:0] period  [NCH];
    logic [PER_W-1:0] per_cnt [NCH];
    logic [31:0]      hold    [NCH];
    logic [7:0]       seq     [NCH];
    logic [NCH-1:0]   ch_on, expire, capture, pend, gnt_vec, drop_vec;
    logic [CW-1:0]    rr_ptr, cur, gnt_idx;
    logic [SW-1:0]    rr_sum, drop_inc;
    logic [16:0]      drop_sum;
    logic [OW-1:0]    to_cnt;
    logic             gnt_found, do_grant, do_ack, do_tmo;
    logic             unused_src;

    assign unused_src = ^src_data;
    assign tick       = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            period[k]  = cfg_period[k*PER_W +: PER_W];
            ch_on[k]   = cfg_en[k] && (period[k] != '0);
            expire[k]  = tick && ch_on[k] && (per_cnt[k] == '0);
            capture[k] = expire[k] && src_valid[k];
        end
    end

    // A period change is only seen at reload, so a running countdown always completes.
    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NCH; k++) per_cnt[k] <= '0;
        end else if (tick) begin
            for (int k = 0; k < NCH; k++) begin
                if (!ch_on[k])              per_cnt[k] <= '0;
                else if (per_cnt[k] == '0)  per_cnt[k] <= period[k] - 1'b1;
                else                        per_cnt[k] <= per_cnt[k] - 1'b1;
            end
        end
    end

    // NOTE: hold is pure payload, only ever read behind pend, so it carries no reset.
    always_ff @(posedge clk_50m) begin
        for (int k = 0; k < NCH; k++)
            if (capture[k]) hold[k] <= src_data[k*MW + MW - 32 +: 32];
    end

    // NOTE: blocking assignments are correct here: rr_sum is scratch reused per iteration,
    // and every comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_sum    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            rr_sum = {1'b0, rr_ptr} + SW'(i);
            if (rr_sum >= NCH_S) rr_sum = rr_sum - NCH_S;
            if (pend[rr_sum[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (gnt_found) state_nxt = S_REQ;
            S_REQ:    if (u_ack[cur] || (to_cnt == TO_MAX)) state_nxt = S_ACKLOW;
            S_ACKLOW: if (u_ack == '0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        do_grant = 1'b0;
        do_ack   = 1'b0;
        do_tmo   = 1'b0;
        case (state)
            S_IDLE: do_grant = gnt_found;
            S_REQ: begin
                if (u_ack[cur])             do_ack = 1'b1;
                else if (to_cnt == TO_MAX)  do_tmo = 1'b1;
            end
            default: ;
        endcase
        busy = (state != S_IDLE);
    end

    assign gnt_vec  = do_grant ? (NCH'(1) << gnt_idx) : '0;
    // A capture landing on the channel being granted refills pend and is not a drop.
    assign drop_vec = capture & pend & ~gnt_vec;

    always_comb begin
        drop_inc = '0;
        for (int k = 0; k < NCH; k++) drop_inc = drop_inc + SW'(drop_vec[k]);
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            pend     <= '0;
            drop_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (capture[k])                          pend[k] <= 1'b1;
                else if (gnt_vec[k] || (tick && !ch_on[k])) pend[k] <= 1'b0;
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (do_tmo && (tmo_cnt != 8'hFF)) tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            u_req  <= '0;
            m_msg  <= '0;
            cur    <= '0;
            rr_ptr <= '0;
            to_cnt <= '0;
            for (int k = 0; k < NCH; k++) seq[k] <= '0;
        end else begin
            if (do_grant) begin
                cur    <= gnt_idx;
                u_req  <= gnt_vec;
                to_cnt <= '0;
                m_msg[gnt_idx*MW +: MW] <= {hold[gnt_idx], seq[gnt_idx], {(MW-40){1'b0}}};
            end else if (do_ack || do_tmo) begin
                u_req  <= '0;
                rr_ptr <= (cur == LAST_CH) ? '0 : cur + 1'b1;
            end else if (state == S_REQ) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (do_ack) seq[cur] <= seq[cur] + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: uart responder model plus scoreboard of expected messages,
// a vector table for single-channel runs and directed multi-cycle sequences.
module tb_uart_tx_sched;
    localparam int NCH = 7, PER_W = 16, TB_DIV = 10, ACK_DLY = 2, ACK_LEN = 2;

    logic                 clk_50m = 1'b0;
    logic                 rstn;
    logic [NCH-1:0]       cfg_en, src_valid, u_req, u_ack;
    logic [NCH*PER_W-1:0] cfg_period;
    logic [NCH*64-1:0]    src_data, m_msg;
    logic [15:0]          drop_cnt;
    logic [7:0]           tmo_cnt;
    logic                 busy;

    uart_tx_sched #(.NCH(NCH), .WIDTH(63), .PER_W(PER_W), .TICK_DIV(TB_DIV), .ACK_TO(64)) dut (
        .rstn(rstn), .clk_50m(clk_50m), .cfg_en(cfg_en), .cfg_period(cfg_period),
        .src_valid(src_valid), .src_data(src_data), .u_req(u_req), .u_ack(u_ack),
        .m_msg(m_msg), .drop_cnt(drop_cnt), .tmo_cnt(tmo_cnt), .busy(busy)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct { int ch; logic [31:0] payload; logic [7:0] seq; } exp_t;
    typedef struct { int ch; bit en; logic [15:0] period; bit valid; logic [31:0] payload; int exp_sends; } vec_t;

    exp_t       sb[$];
    exp_t       last_exp [NCH];
    logic [7:0] exp_seq  [NCH];
    int         exp_rr, exp_drop, exp_tmo;
    int         checks = 0, errors = 0, sends = 0;
    bit         ack_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input int ch, input logic [31:0] p);
        exp_t e;
        e = '{ch: ch, payload: p, seq: exp_seq[ch]};
        sb.push_back(e);
        last_exp[ch] = e;
        exp_seq[ch]  = exp_seq[ch] + 8'd1;
    endfunction

    function automatic void model_reset();
        sb.delete();
        for (int k = 0; k < NCH; k++) exp_seq[k] = '0;
        exp_rr = 0; exp_drop = 0; exp_tmo = 0;
    endfunction

    task automatic set_src(input int ch, input logic [15:0] per, input logic [31:0] p);
        cfg_period[ch*PER_W +: PER_W] = per;
        src_data[ch*64 +: 64]         = {p, 32'hDEAD_BEEF};
    endtask

    task automatic wait_req(input int ch, input string name);
        int n = 0;
        while (!u_req[ch] && n < 40) begin
            @(negedge clk_50m);
            n++;
        end
        check(name, u_req[ch], 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(negedge clk_50m);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // uart model: acks the requested channel after ACK_DLY cycles for ACK_LEN cycles.
    initial begin : uart_model
        int   rch;
        exp_t e;
        u_ack = '0;
        forever begin
            @(negedge clk_50m);
            if (ack_on && rstn && u_req != '0) begin
                rch = 0;
                for (int i = 0; i < NCH; i++) if (u_req[i]) rch = i;
                check("req_onehot", $countones(u_req), 1);
                repeat (ACK_DLY) @(negedge clk_50m);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: ch %0d sent while none expected", rch);
                end else begin
                    e = sb.pop_front();
                    check("send_ch", rch, e.ch);
                    check("send_msg", m_msg[rch*64 +: 64], {e.payload, e.seq, 24'h0});
                end
                sends++;
                u_ack[rch] = 1'b1;
                repeat (ACK_LEN) @(negedge clk_50m);
                u_ack = '0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs [6];
        int   s0, hi, lat;

        vecs[0] = '{ch: 2, en: 1'b1, period: 16'd3, valid: 1'b1, payload: 32'hC0DE_0002, exp_sends: 3};
        vecs[1] = '{ch: 5, en: 1'b1, period: 16'd1, valid: 1'b1, payload: 32'h5555_0005, exp_sends: 8};
        vecs[2] = '{ch: 3, en: 1'b1, period: 16'd2, valid: 1'b0, payload: 32'h3333_0003, exp_sends: 0};
        vecs[3] = '{ch: 3, en: 1'b1, period: 16'd0, valid: 1'b1, payload: 32'h3333_0013, exp_sends: 0};
        vecs[4] = '{ch: 6, en: 1'b0, period: 16'd1, valid: 1'b1, payload: 32'h6666_0006, exp_sends: 0};
        vecs[5] = '{ch: 4, en: 1'b1, period: 16'd4, valid: 1'b1, payload: 32'h4444_0004, exp_sends: 2};

        rstn = 1'b0; cfg_en = '0; cfg_period = '0; src_valid = '0; src_data = '0;
        model_reset();
        repeat (3) @(negedge clk_50m);
        check("rst_u_req", u_req, 0);
        check("rst_m_msg_lo", m_msg[63:0], 0);
        check("rst_m_msg_hi", m_msg[NCH*64-1:NCH*64-64], 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_tmo", tmo_cnt, 0);
        check("rst_busy", busy, 0);
        rstn   = 1'b1;
        ack_on = 1'b1;

        // Single-channel vectors: any 80-cycle window holds exactly 8 ticks.
        for (int v = 0; v < 6; v++) begin
            set_src(vecs[v].ch, vecs[v].period, vecs[v].payload);
            for (int k = 0; k < vecs[v].exp_sends; k++) push(vecs[v].ch, vecs[v].payload);
            s0 = sends;
            cfg_en[vecs[v].ch]    = vecs[v].en;
            src_valid[vecs[v].ch] = vecs[v].valid;
            repeat (80) @(negedge clk_50m);
            src_valid = '0;
            drain($sformatf("vec%0d_drain", v));
            check($sformatf("vec%0d_sends", v), sends - s0, vecs[v].exp_sends);
            check($sformatf("vec%0d_drops", v), drop_cnt, exp_drop);
            cfg_en = '0;
            repeat (12) @(negedge clk_50m);
            if (vecs[v].exp_sends > 0) exp_rr = (vecs[v].ch + 1) % NCH;
        end

        // All channels expire together: two round-robin rounds starting at rr_ptr.
        for (int k = 0; k < NCH; k++) set_src(k, 16'd5, 32'hA000_0000 + k);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NCH; i++) push((exp_rr + i) % NCH, 32'hA000_0000 + (exp_rr + i) % NCH);
        s0 = sends;
        cfg_en = '1; src_valid = '1;
        repeat (80) @(negedge clk_50m);
        src_valid = '0;
        drain("rr_drain");
        check("rr_sends", sends - s0, 2 * NCH);
        check("rr_drops", drop_cnt, exp_drop);
        cfg_en = '0;
        repeat (12) @(negedge clk_50m);

        // Ack timeout on ch0, then the retry keeps the same sequence number.
        ack_on = 1'b0;
        set_src(0, 16'd1, 32'h7100_0000);
        cfg_en[0] = 1'b1; src_valid[0] = 1'b1;
        wait_req(0, "tmo_req_seen");
        src_valid[0] = 1'b0;
        hi = 0;
        while (u_req[0] && hi < 200) begin
            @(negedge clk_50m);
            hi++;
        end
        exp_tmo++;
        exp_rr = 1;
        check("tmo_req_len", hi, 64);
        check("tmo_cnt", tmo_cnt, exp_tmo);
        @(negedge clk_50m);
        check("tmo_acklow_exit", busy, 0);
        ack_on = 1'b1;
        set_src(0, 16'd1, 32'h7100_0001);
        push(0, 32'h7100_0001);
        src_valid[0] = 1'b1;
        wait_req(0, "tmo_retry_req");
        src_valid[0] = 1'b0;
        drain("tmo_drain");
        cfg_en = '0;
        repeat (12) @(negedge clk_50m);

        // ch1 captures twice while ch0 is outstanding: one drop, newest sample sent.
        ack_on = 1'b0;
        set_src(0, 16'd1, 32'h0B0B_0000);
        cfg_en[0] = 1'b1; src_valid[0] = 1'b1;
        wait_req(0, "drop_ch0_req");
        src_valid[0] = 1'b0;
        set_src(1, 16'd1, 32'h1111_AAAA);
        cfg_en[1] = 1'b1; src_valid[1] = 1'b1;
        repeat (10) @(negedge clk_50m);
        set_src(1, 16'd1, 32'h1111_BBBB);
        repeat (10) @(negedge clk_50m);
        src_valid[1] = 1'b0;
        exp_drop++;
        check("drop_cnt", drop_cnt, exp_drop);
        check("drop_req_held", u_req, 7'b000_0001);
        push(0, 32'h0B0B_0000);
        push(1, 32'h1111_BBBB);
        s0 = sends;
        ack_on = 1'b1;
        drain("drop_drain");
        check("drop_sends", sends - s0, 2);
        check("drop_tmo_kept", tmo_cnt, exp_tmo);
        check("slot2_kept", m_msg[2*64 +: 64], {last_exp[2].payload, last_exp[2].seq, 24'h0});
        cfg_en = '0;
        repeat (12) @(negedge clk_50m);

        // Reset during S_REQ, then first request latency from release.
        ack_on = 1'b0;
        set_src(4, 16'd1, 32'h4444_DEAD);
        cfg_en[4] = 1'b1; src_valid[4] = 1'b1;
        wait_req(4, "rst_mid_req");
        rstn = 1'b0;
        #1;
        check("rst_mid_u_req", u_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_drop", drop_cnt, 0);
        check("rst_mid_tmo", tmo_cnt, 0);
        check("rst_mid_msg4", m_msg[4*64 +: 64], 0);
        model_reset();
        set_src(4, 16'd1, 32'h4444_0F0F);
        push(4, 32'h4444_0F0F);
        ack_on = 1'b1;
        repeat (2) @(negedge clk_50m);
        s0   = sends;
        rstn = 1'b1;
        lat  = 0;
        while (!u_req[4] && lat < 40) begin
            @(negedge clk_50m);
            lat++;
        end
        src_valid[4] = 1'b0;
        check("post_rst_latency", lat, TB_DIV + 1);
        drain("post_rst_drain");
        check("post_rst_sends", sends - s0, 1);
        check("post_rst_drop", drop_cnt, exp_drop);
        check("post_rst_tmo", tmo_cnt, exp_tmo);
        cfg_en = '0;
        repeat (12) @(negedge clk_50m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
